// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_COUNT   = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/word_packer.sv
// Collects four bytes little-endian into a 32-bit word and strobes it out.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    output logic        lane_last,
    output logic [31:0] word,
    output logic        word_vld
);

    logic [1:0]  lane_q,  lane_d;
    logic [23:0] shreg_q, shreg_d;
    logic [31:0] word_q,  word_d;
    logic        vld_q,   vld_d;

    // Next-state: shift bytes in from the top so byte 0 ends up in [7:0].
    always_comb begin
        lane_d  = lane_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        vld_d   = 1'b0;
        if (clr) begin
            lane_d  = 2'd0;
            shreg_d = 24'd0;
        end else if (byte_vld) begin
            if (lane_q == 2'd3) begin
                word_d = {byte_data, shreg_q};
                vld_d  = 1'b1;
                lane_d = 2'd0;
            end else begin
                shreg_d = {byte_data, shreg_q[23:8]};
                lane_d  = lane_q + 2'd1;
            end
        end
    end

    // State registers; the assembled word holds until the next one completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q  <= 2'd0;
            shreg_q <= 24'd0;
            word_q  <= 32'd0;
            vld_q   <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
        end
    end

    assign lane_last = (lane_q == 2'd3);
    assign word      = word_q;
    assign word_vld  = vld_q;

endmodule

// File: rtl/program_loader.sv
// Frame parser feeding the CPU ROM programming port: header, count,
// packed data words and a trailing additive checksum, with idle timeout.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] HEADER         = HEADER_DEFAULT,
    parameter int         MAX_WORDS      = 64,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        edit,
    output logic [7:0]  line,
    output logic [31:0] code,
    output logic        send,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] MAX_B    = 8'(MAX_WORDS);

    state_e        state_q, state_d;
    logic [1:0]    err_q,   err_d;
    logic [7:0]    sum_q,   sum_d;
    logic [6:0]    idx_q,   idx_d;
    logic [6:0]    num_q,   num_d;
    logic [7:0]    line_q,  line_d;
    logic [TW-1:0] tmo_q,   tmo_d;

    logic          pk_clr;
    logic          pk_vld_in;
    logic          pk_last;
    logic [31:0]   pk_word;
    logic          pk_word_vld;

    // Lane position is meaningless outside a data phase, so keep it cleared;
    // this also drops a half-built word on timeout or error.
    assign pk_clr    = (state_q != DATA);
    assign pk_vld_in = rx_valid && (state_q == DATA);

    word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (pk_clr),
        .byte_vld  (pk_vld_in),
        .byte_data (rx_data),
        .lane_last (pk_last),
        .word      (pk_word),
        .word_vld  (pk_word_vld)
    );

    // Next-state: frame sequencing, running checksum, word index and timeout.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        num_d   = num_q;
        line_d  = line_q;
        tmo_d   = '0;
        case (state_q)
            IDLE, ERROR: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_d = COUNT;
                    err_d   = ERR_NONE;
                end
            end
            COUNT: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_B) begin
                        state_d = ERROR;
                        err_d   = ERR_COUNT;
                    end else begin
                        num_d   = rx_data[6:0];
                        sum_d   = rx_data;
                        idx_d   = 7'd0;
                        state_d = DATA;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    sum_d = sum_q + rx_data;
                    if (pk_last) begin
                        line_d = {idx_q[5:0], 2'b00};
                        idx_d  = idx_q + 7'd1;
                        if (idx_d == num_q) state_d = CHECK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_CHK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wipes any partially loaded frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            sum_q   <= 8'd0;
            idx_q   <= 7'd0;
            num_q   <= 7'd0;
            line_q  <= 8'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            line_q  <= line_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy     = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
    assign edit     = busy;
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERROR);
    assign err_code = err_q;
    assign line     = line_q;
    assign code     = pk_word;
    assign send     = pk_word_vld;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a short timeout.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        edit, send, busy, done, error;
    logic [7:0]  line;
    logic [31:0] code;
    logic [1:0]  err_code;

    int vec  = 0;
    int errs = 0;
    int send_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    program_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .edit     (edit),
        .line     (line),
        .code     (code),
        .send     (send),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (send) send_cnt++;
        if (done) done_cnt++;
        if (send && done) overlap_cnt++;
    end

    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vec++; if ({edit, send, busy, done, error} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b expected 00000", {edit, send, busy, done, error}); end
        vec++; if (line !== 8'h00) begin errs++; $display("FAIL reset_line: got %h expected 00", line); end
        vec++; if (code !== 32'h0) begin errs++; $display("FAIL reset_code: got %h expected 00000000", code); end
        vec++; if (err_code !== 2'd0) begin errs++; $display("FAIL reset_err: got %0d expected 0", err_code); end
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_single_word;
        int s0, d0;
        s0 = send_cnt; d0 = done_cnt;
        put(8'hA5);
        vec++; if ({busy, edit} !== 2'b11) begin errs++; $display("FAIL sw_busy_edit: got %b expected 11", {busy, edit}); end
        put(8'h01); put(8'h13); put(8'h01); put(8'h02);
        vec++; if (send !== 1'b0) begin errs++; $display("FAIL sw_early_send: got %b expected 0", send); end
        put(8'h00);
        vec++; if (send !== 1'b1) begin errs++; $display("FAIL sw_send: got %b expected 1", send); end
        vec++; if (line !== 8'h00) begin errs++; $display("FAIL sw_line: got %h expected 00", line); end
        vec++; if (code !== 32'h00020113) begin errs++; $display("FAIL sw_code: got %h expected 00020113", code); end
        put(8'h17);
        vec++; if ({done, edit, error} !== 3'b100) begin errs++; $display("FAIL sw_done: got %b expected 100", {done, edit, error}); end
        vec++; if (err_code !== 2'd0) begin errs++; $display("FAIL sw_err: got %0d expected 0", err_code); end
        idle(1);
        vec++; if ({done, busy} !== 2'b00) begin errs++; $display("FAIL sw_done_pulse: got %b expected 00", {done, busy}); end
        idle(2);
        vec++; if (send_cnt - s0 !== 1) begin errs++; $display("FAIL sw_send_count: got %0d expected 1", send_cnt - s0); end
        vec++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL sw_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        int s0;
        s0 = send_cnt;
        put(8'hA5); put(8'h02);
        repeat (4) put(8'h11);
        vec++; if ({send, line, code} !== {1'b1, 8'h00, 32'h11111111}) begin errs++; $display("FAIL b2b_w0: got %b/%h/%h expected 1/00/11111111", send, line, code); end
        repeat (4) put(8'h22);
        vec++; if ({send, line, code} !== {1'b1, 8'h04, 32'h22222222}) begin errs++; $display("FAIL b2b_w1: got %b/%h/%h expected 1/04/22222222", send, line, code); end
        put(8'hCE);
        vec++; if ({done, send} !== 2'b10) begin errs++; $display("FAIL b2b_done: got %b expected 10", {done, send}); end
        idle(2);
        vec++; if (send_cnt - s0 !== 2) begin errs++; $display("FAIL b2b_send_count: got %0d expected 2", send_cnt - s0); end
    endtask

    task automatic test_bad_count;
        int s0;
        s0 = send_cnt;
        put(8'hA5); put(8'h00);
        vec++; if ({error, err_code, edit} !== {1'b1, 2'd1, 1'b0}) begin errs++; $display("FAIL cnt0: got %b/%0d/%b expected 1/1/0", error, err_code, edit); end
        put(8'h13); put(8'h42);
        vec++; if ({error, err_code} !== {1'b1, 2'd1}) begin errs++; $display("FAIL cnt_sticky: got %b/%0d expected 1/1", error, err_code); end
        put(8'hA5);
        vec++; if ({error, err_code, busy} !== {1'b0, 2'd0, 1'b1}) begin errs++; $display("FAIL cnt_restart: got %b/%0d/%b expected 0/0/1", error, err_code, busy); end
        put(8'h41);
        vec++; if ({error, err_code} !== {1'b1, 2'd1}) begin errs++; $display("FAIL cnt41: got %b/%0d expected 1/1", error, err_code); end
        put(8'hA5); put(8'h01); put(8'h13); put(8'h01); put(8'h02); put(8'h00); put(8'h17);
        vec++; if ({done, error, err_code} !== {1'b1, 1'b0, 2'd0}) begin errs++; $display("FAIL cnt_recover: got %b/%b/%0d expected 1/0/0", done, error, err_code); end
        idle(2);
        vec++; if (send_cnt - s0 !== 1) begin errs++; $display("FAIL cnt_send_count: got %0d expected 1", send_cnt - s0); end
    endtask

    task automatic test_bad_checksum;
        int s0, d0;
        s0 = send_cnt; d0 = done_cnt;
        put(8'hA5); put(8'h01); put(8'h13); put(8'h01); put(8'h02); put(8'h00); put(8'h18);
        vec++; if ({error, err_code, edit, done} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin errs++; $display("FAIL chk_err: got %b/%0d/%b/%b expected 1/2/0/0", error, err_code, edit, done); end
        idle(3);
        vec++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL chk_done_count: got %0d expected 0", done_cnt - d0); end
        vec++; if (send_cnt - s0 !== 1) begin errs++; $display("FAIL chk_send_count: got %0d expected 1", send_cnt - s0); end
    endtask

    task automatic test_timeout;
        int s0;
        s0 = send_cnt;
        put(8'hA5); put(8'h01); put(8'h13); put(8'h01);
        idle(15);
        vec++; if ({error, busy} !== 2'b01) begin errs++; $display("FAIL tmo_early: got %b expected 01", {error, busy}); end
        idle(1);
        vec++; if ({error, err_code, edit} !== {1'b1, 2'd3, 1'b0}) begin errs++; $display("FAIL tmo_err: got %b/%0d/%b expected 1/3/0", error, err_code, edit); end
        idle(2);
        vec++; if (send_cnt - s0 !== 0) begin errs++; $display("FAIL tmo_no_send: got %0d expected 0", send_cnt - s0); end
        put(8'hA5); put(8'h01); put(8'h13); put(8'h01); put(8'h02); put(8'h00);
        vec++; if ({send, code} !== {1'b1, 32'h00020113}) begin errs++; $display("FAIL tmo_next_word: got %b/%h expected 1/00020113", send, code); end
        put(8'h17);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL tmo_next_done: got %b expected 1", done); end
        idle(2);
    endtask

    task automatic test_reset_midload;
        put(8'hA5); put(8'h02);
        repeat (4) put(8'h11);
        put(8'h22); put(8'h22);
        rx_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vec++; if ({edit, send, busy, done, error, err_code, line} !== 15'b0) begin errs++; $display("FAIL mid_rst_ctl: got %b expected all zero", {edit, send, busy, done, error, err_code, line}); end
        vec++; if (code !== 32'h0) begin errs++; $display("FAIL mid_rst_code: got %h expected 00000000", code); end
        rst = 1'b1;
        put(8'h00); put(8'hFF);
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL junk_ignored: got %b expected 0", busy); end
        put(8'hA5); put(8'h01); put(8'h13); put(8'h01); put(8'h02); put(8'h00);
        vec++; if ({send, line, code} !== {1'b1, 8'h00, 32'h00020113}) begin errs++; $display("FAIL mid_rst_word: got %b/%h/%h expected 1/00/00020113", send, line, code); end
        put(8'h17);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL mid_rst_done: got %b expected 1", done); end
        idle(2);
    endtask

    task automatic test_header_as_data;
        put(8'hA5); put(8'h01); put(8'hA5);
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL hdr_data_busy: got %b expected 1", busy); end
        put(8'hFF); put(8'h00); put(8'h00);
        vec++; if ({send, code} !== {1'b1, 32'h0000FFA5}) begin errs++; $display("FAIL hdr_data_code: got %b/%h expected 1/0000ffa5", send, code); end
        put(8'hA5);
        vec++; if ({done, error} !== 2'b10) begin errs++; $display("FAIL hdr_chk_done: got %b expected 10", {done, error}); end
        idle(2);
    endtask

    task automatic test_max_words;
        int s0;
        s0 = send_cnt;
        put(8'hA5); put(8'h40);
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 4; b++) put(8'(w));
        end
        vec++; if ({send, line, code} !== {1'b1, 8'hFC, 32'h3F3F3F3F}) begin errs++; $display("FAIL max_last: got %b/%h/%h expected 1/fc/3f3f3f3f", send, line, code); end
        put(8'hC0);
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL max_done: got %b expected 1", done); end
        idle(2);
        vec++; if (send_cnt - s0 !== 64) begin errs++; $display("FAIL max_send_count: got %0d expected 64", send_cnt - s0); end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_back_to_back;
        test_bad_count;
        test_bad_checksum;
        test_timeout;
        test_reset_midload;
        test_header_as_data;
        test_max_words;
        vec++; if (overlap_cnt !== 0) begin errs++; $display("FAIL send_done_overlap: got %0d expected 0", overlap_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the CPU's ROM programming port (edit/line/code/send).
- Consumes a byte stream from a UART receiver and validates the framed program image.
- Packs each group of 4 bytes into a 32-bit instruction word and writes it at byte address index*4, matching the counter STEP of 4.
- Reports completion or a framing, checksum or timeout error to the host-facing logic.

Parameters:
HEADER, 8'hA5, start-of-frame byte
MAX_WORDS, 64, maximum instruction count; 64*4 fills the 8-bit line space
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes inside a frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
rx_valid  in  1  rx_data valid this cycle; back-to-back allowed; no backpressure
rx_data  in  8  received byte
edit  out  1  ROM programming mode; to CPU edit
line  out  8  ROM byte address of current word; to CPU line
code  out  32  assembled instruction word; to CPU code
send  out  1  one-cycle write strobe; to CPU send
busy  out  1  frame in progress (state not IDLE/DONE/ERROR)
done  out  1  one-cycle pulse: frame accepted, checksum good
error  out  1  sticky error flag
err_code  out  2  0 none, 1 bad count, 2 checksum, 3 timeout

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. Every output is 0: edit, line, code, send, busy, done, error, err_code. Internal sum, word index and timeout counter are also cleared. Reset applies mid-frame too; no partial state survives.
- Frame format: HEADER, COUNT (N), N*4 data bytes, CHK.
  - Data bytes are little-endian per word: the first byte goes to code[7:0] (opcode field), the fourth to code[31:24].
  - CHK = (COUNT + all data bytes) mod 256.
- IDLE: bytes other than HEADER are ignored. HEADER -> COUNT state; edit=1 from the next cycle.
- COUNT: byte 0 or byte > MAX_WORDS -> ERROR, err_code=1. Otherwise latch N, sum=N, index=0, byte lane=0 -> DATA.
- DATA: each accepted byte goes into lane 0..3 and is added to sum.
  - On lane 3, the next cycle has: code = packed word, line = index*4 (8-bit), send=1 for exactly one cycle.
  - code and line then hold until the next word.
  - Index increments; when index reaches N -> CHECK.
- CHECK: byte == sum -> DONE: done=1 for one cycle, edit=0, error=0, err_code=0. Otherwise -> ERROR, err_code=2.
- Words already sent before a checksum error remain in the ROM; the host resends the whole frame.
- DONE: returns to IDLE the following cycle.
- ERROR: edit=0, error=1, err_code held.
  - A HEADER byte restarts a frame: error and err_code clear when COUNT is entered.
  - All other bytes are ignored.
- Timeout: the counter runs in COUNT/DATA/CHECK and clears on every accepted byte. Reaching TIMEOUT_CYCLES -> ERROR, err_code=3; a partially packed word is discarded and no send is issued.
- busy=1 in COUNT, DATA and CHECK.
- Boundaries:
  - N=MAX_WORDS: last line=0xFC, no wrap.
  - HEADER value inside DATA or CHECK is treated as data, not a restart.
  - rx_valid during the send cycle is accepted normally.
  - send and done never coincide.
- Latency: fourth data byte sampled -> send on the next edge; CHK sampled -> done on the next edge.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, COUNT, DATA, CHECK, DONE, ERROR);
  - error code constants ERR_NONE, ERR_COUNT, ERR_CHK, ERR_TIMEOUT;
  - HEADER default.
- One sub-module, word_packer: byte lane counter, 32-bit shift/pack register and word-complete strobe. The FSM, checksum and timeout stay in program_loader.

Test Plan:
- Single word: A5 01 13 01 02 00 17 -> send once with line=0x00, code=0x00020113; then done=1, err_code=0, edit back to 0.
- Two words, back-to-back bytes: A5 02, 11 x4, 22 x4, CE -> sends at line 0x00 (code 0x11111111) and 0x04 (code 0x22222222); done=1.
- Bad count: A5 00 -> err_code=1, error=1, no send. Same for A5 41 with MAX_WORDS=64. A following A5 01 13 01 02 00 17 succeeds and clears error.
- Bad checksum: single-word frame ending in 18 -> one send, then error=1, err_code=2, done never asserted.
- Timeout (TIMEOUT_CYCLES=16): A5 01 13 01, then idle -> after 16 cycles err_code=3, edit=0, no send.
- Reset mid-load: rst=0 during DATA -> all outputs 0 after the edge; leading junk bytes 00 FF before A5 are ignored afterwards.
